seq_and_checker: RTL

// Synthesizable, parametrised run-time checker for the "start -> A held and B held after a delay" sequence property.
// Per channel: a rising start arms a check window beginning the next cycle (|=> semantics).

---
 rtl/seq_and_checker.sv | 115 +++++++++++
 1 files changed

// File: rtl/seq_and_checker.sv
// Per-channel run-time checker for "rising start |=> A held A_LEN cycles and B held B_LEN cycles from offset B_DLY".
// Decisions are registered: pass/fail pulse the cycle after the deciding edge; shared saturating pass/fail counters.
module seq_and_checker #(
  parameter int CH    = 2,
  parameter int A_LEN = 2,
  parameter int B_DLY = 1,
  parameter int B_LEN = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CH-1:0]    start,
  input  logic [CH-1:0]    a,
  input  logic [CH-1:0]    b,
  output logic [CH-1:0]    busy,
  output logic [CH-1:0]    pass,
  output logic [CH-1:0]    fail,
  output logic [CH-1:0]    ovr,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int W  = (A_LEN > B_DLY + B_LEN) ? A_LEN : B_DLY + B_LEN;
  localparam int KW = $clog2(W + 1);
  localparam int PW = $clog2(CH + 1);
  localparam logic [KW-1:0] K_A    = KW'(A_LEN);
  localparam logic [KW-1:0] K_B0   = KW'(B_DLY);
  localparam logic [KW-1:0] K_B1   = KW'(B_DLY + B_LEN);
  localparam logic [KW-1:0] K_LAST = KW'(W - 1);

  typedef enum logic {IDLE, CHECK} state_t;

  state_t        st [CH];
  logic [KW-1:0] k  [CH];
  logic [CH-1:0] start_d, rise, viol, last, pass_nxt, fail_nxt;
  logic [PW-1:0] npass, nfail;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [PW-1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(n);
    return (s > {1'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    rise     = start & ~start_d;
    viol     = '0;
    last     = '0;
    pass_nxt = '0;
    fail_nxt = '0;
    npass    = '0;
    nfail    = '0;
    for (int i = 0; i < CH; i++) begin
      viol[i] = ((k[i] < K_A) & ~a[i]) | ((k[i] >= K_B0) & (k[i] < K_B1) & ~b[i]);
      last[i] = (k[i] == K_LAST);
      // Disabling mid-check aborts silently, so en gates the decision itself.
      if (en && st[i] == CHECK) begin
        fail_nxt[i] = viol[i];
        pass_nxt[i] = ~viol[i] & last[i];
      end
      npass = npass + PW'(pass_nxt[i]);
      nfail = nfail + PW'(fail_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // All-ones so a start held high through reset is not seen as a rise.
      start_d  <= '1;
      busy     <= '0;
      pass     <= '0;
      fail     <= '0;
      ovr      <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      for (int i = 0; i < CH; i++) begin
        st[i] <= IDLE;
        k[i]  <= '0;
      end
    end else begin
      start_d  <= start;
      pass     <= pass_nxt;
      fail     <= fail_nxt;
      pass_cnt <= sat_add(pass_cnt, npass);
      fail_cnt <= sat_add(fail_cnt, nfail);
      for (int i = 0; i < CH; i++) begin
        case (st[i])
          IDLE: begin
            if (en && rise[i]) begin
              st[i]   <= CHECK;
              k[i]    <= '0;
              busy[i] <= 1'b1;
            end
          end
          CHECK: begin
            // A rise during a check, including its final edge, never restarts it.
            if (en && rise[i]) ovr[i] <= 1'b1;
            if (!en || viol[i] || last[i]) begin
              st[i]   <= IDLE;
              k[i]    <= '0;
              busy[i] <= 1'b0;
            end else begin
              k[i] <= k[i] + KW'(1);
            end
          end
          default: begin
            st[i]   <= IDLE;
            busy[i] <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
